// File: rtl/sirius_fetch_pkg.sv
// Shared types for the fetch PC generator: translation record, FSM states,
// pending-redirect kinds and the unmapped-segment helpers.
package sirius_fetch_pkg;

    localparam logic [1:0] KSEG_UNMAPPED = 2'b10;

    typedef struct packed {
        logic [31:0] paddr;
        logic        miss;
        logic        illegal;
        logic        invalid;
        logic        uncached;
    } pc_xlate_t;

    typedef enum logic {
        RUN,
        XLATE
    } fetch_state_e;

    typedef enum logic [1:0] {
        NONE,
        BRANCH,
        EXCEPTION
    } redirect_e;

    function automatic logic is_unmapped(input logic [1:0] seg);
        return seg == KSEG_UNMAPPED;
    endfunction

    // kseg0/kseg1 translate by stripping the top bits; bit 29 selects kseg1 (uncached)
    function automatic pc_xlate_t unmapped_xlate(input logic [29:0] low);
        pc_xlate_t x;
        x.paddr    = {3'b000, low[28:0]};
        x.miss     = 1'b0;
        x.illegal  = 1'b0;
        x.invalid  = 1'b0;
        x.uncached = low[29];
        return x;
    endfunction

endpackage

// File: rtl/pc_xlate_cache.sv
// One-entry page translation cache: VPN/PFN/uncached store with a
// combinational hit compare, a fill port and a flush that beats a fill.
module pc_xlate_cache #(
    parameter int unsigned VPN_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [VPN_W-1:0] lookup_vpn,
    output logic             hit,
    output logic [VPN_W-1:0] hit_pfn,
    output logic             hit_uncached,
    input  logic             fill,
    input  logic [VPN_W-1:0] fill_vpn,
    input  logic [VPN_W-1:0] fill_pfn,
    input  logic             fill_uncached,
    input  logic             flush
);

    logic             valid_q;
    logic [VPN_W-1:0] vpn_q;
    logic [VPN_W-1:0] pfn_q;
    logic             uncached_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (fill) begin
            valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill && !flush) begin
            vpn_q      <= fill_vpn;
            pfn_q      <= fill_pfn;
            uncached_q <= fill_uncached;
        end
    end

    assign hit          = valid_q && (vpn_q == lookup_vpn);
    assign hit_pfn      = pfn_q;
    assign hit_uncached = uncached_q;

endmodule

// File: rtl/pc_fetch_gen.sv
// Fetch PC generator: advances/redirects the virtual PC and translates it
// through a one-entry cache backed by a single handshaked TLB port.
//
//   state | meaning
//   RUN   | PC may advance or redirect; new PC translated in the same cycle
//   XLATE | cache missed; tlb_req held with tlb_vaddr = pc until tlb_ack
module pc_fetch_gen
    import sirius_fetch_pkg::*;
#(
    parameter int unsigned FETCH_WIDTH  = 2,
    parameter logic [31:0] RESET_VECTOR = 32'hbfc0_0000,
    parameter int unsigned PAGE_BITS    = 12
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               pc_en,
    input  logic                               fifo_full,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0]   fetch_accept,
    input  logic                               branch_valid,
    input  logic [31:0]                        branch_address,
    input  logic                               exception_valid,
    input  logic [31:0]                        exception_address,
    input  logic                               xlate_flush,
    output logic                               tlb_req,
    output logic [31:0]                        tlb_vaddr,
    input  logic                               tlb_ack,
    input  logic [31:0]                        tlb_paddr,
    input  logic                               tlb_miss,
    input  logic                               tlb_illegal,
    input  logic                               tlb_invalid,
    input  logic                               tlb_uncached,
    output logic [31:0]                        pc_address,
    output logic [31:0]                        pc_address_psy,
    output logic                               pc_valid,
    output logic                               pc_tlb_miss,
    output logic                               pc_tlb_illegal,
    output logic                               pc_tlb_invalid,
    output logic                               pc_tlb_uncached
);

    localparam int unsigned AW    = $clog2(FETCH_WIDTH + 1);
    localparam int unsigned VPN_W = 32 - PAGE_BITS;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q;
    pc_xlate_t    xlate_q, xlate_d;
    logic         valid_q, valid_d;
    redirect_e    pend_kind_q, pend_kind_d;
    logic [31:0]  pend_addr_q, pend_addr_d;

    logic [AW-1:0]    accept_c;
    logic [31:0]      step;
    logic             take_pc;
    logic [31:0]      new_pc;
    logic             cache_hit;
    logic [VPN_W-1:0] cache_pfn;
    logic             cache_uncached;
    logic             fill;

    assign accept_c = (fetch_accept > AW'(FETCH_WIDTH)) ? AW'(FETCH_WIDTH) : fetch_accept;
    assign step     = {{(30 - AW){1'b0}}, accept_c, 2'b00};

    // Next-PC selection and pending-redirect bookkeeping
    always_comb begin
        take_pc     = 1'b0;
        new_pc      = pc_q;
        pend_kind_d = pend_kind_q;
        pend_addr_d = pend_addr_q;
        if (state_q == XLATE || !pc_en) begin
            if (exception_valid) begin
                pend_kind_d = EXCEPTION;
                pend_addr_d = exception_address;
            end else if (branch_valid && pend_kind_q != EXCEPTION) begin
                pend_kind_d = BRANCH;
                pend_addr_d = branch_address;
            end
        end else if (exception_valid) begin
            take_pc     = 1'b1;
            new_pc      = exception_address;
            pend_kind_d = NONE;
        end else if (pend_kind_q != NONE) begin
            take_pc     = 1'b1;
            new_pc      = pend_addr_q;
            pend_kind_d = NONE;
        end else if (branch_valid) begin
            take_pc = 1'b1;
            new_pc  = branch_address;
        end else if (!fifo_full && accept_c != '0) begin
            take_pc = 1'b1;
            new_pc  = pc_q + step;
        end
    end

    pc_xlate_cache #(
        .VPN_W (VPN_W)
    ) u_cache (
        .clk           (clk),
        .rst_n         (rst_n),
        .lookup_vpn    (new_pc[31:PAGE_BITS]),
        .hit           (cache_hit),
        .hit_pfn       (cache_pfn),
        .hit_uncached  (cache_uncached),
        .fill          (fill),
        .fill_vpn      (pc_q[31:PAGE_BITS]),
        .fill_pfn      (tlb_paddr[31:PAGE_BITS]),
        .fill_uncached (tlb_uncached),
        .flush         (xlate_flush)
    );

    always_comb begin
        state_d = state_q;
        xlate_d = xlate_q;
        valid_d = valid_q;
        fill    = 1'b0;
        if (state_q == RUN) begin
            if (take_pc) begin
                if (is_unmapped(new_pc[31:30])) begin
                    xlate_d = unmapped_xlate(new_pc[29:0]);
                    valid_d = 1'b1;
                end else if (cache_hit) begin
                    xlate_d.paddr    = {cache_pfn, new_pc[PAGE_BITS-1:0]};
                    xlate_d.miss     = 1'b0;
                    xlate_d.illegal  = 1'b0;
                    xlate_d.invalid  = 1'b0;
                    xlate_d.uncached = cache_uncached;
                    valid_d          = 1'b1;
                end else begin
                    valid_d = 1'b0;
                    state_d = XLATE;
                end
            end
        end else if (tlb_ack) begin
            state_d = RUN;
            // A redirect pending at ack time makes this result stale; drop it
            if (pend_kind_d == NONE) begin
                xlate_d.paddr    = tlb_paddr;
                xlate_d.miss     = tlb_miss;
                xlate_d.illegal  = tlb_illegal;
                xlate_d.invalid  = tlb_invalid;
                xlate_d.uncached = tlb_uncached;
                valid_d          = 1'b1;
                fill             = !(tlb_miss || tlb_illegal || tlb_invalid);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pc_q        <= RESET_VECTOR;
            xlate_q     <= unmapped_xlate(RESET_VECTOR[29:0]);
            valid_q     <= 1'b1;
            pend_kind_q <= NONE;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= new_pc;
            xlate_q     <= xlate_d;
            valid_q     <= valid_d;
            pend_kind_q <= pend_kind_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign tlb_req         = (state_q == XLATE);
    assign tlb_vaddr       = pc_q;
    assign pc_address      = pc_q;
    assign pc_address_psy  = xlate_q.paddr;
    assign pc_valid        = valid_q;
    assign pc_tlb_miss     = xlate_q.miss;
    assign pc_tlb_illegal  = xlate_q.illegal;
    assign pc_tlb_invalid  = xlate_q.invalid;
    assign pc_tlb_uncached = xlate_q.uncached;

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Self-checking bench for pc_fetch_gen: scripted stimulus with expected
// outputs queued per cycle and compared one cycle later.
module tb_pc_fetch_gen;

    logic        clk;
    logic        rst_n;
    logic        pc_en;
    logic        fifo_full;
    logic [1:0]  fetch_accept;
    logic        branch_valid;
    logic [31:0] branch_address;
    logic        exception_valid;
    logic [31:0] exception_address;
    logic        xlate_flush;
    logic        tlb_req;
    logic [31:0] tlb_vaddr;
    logic        tlb_ack;
    logic [31:0] tlb_paddr;
    logic        tlb_miss, tlb_illegal, tlb_invalid, tlb_uncached;
    logic [31:0] pc_address;
    logic [31:0] pc_address_psy;
    logic        pc_valid;
    logic        pc_tlb_miss, pc_tlb_illegal, pc_tlb_invalid, pc_tlb_uncached;

    pc_fetch_gen dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pc_en             (pc_en),
        .fifo_full         (fifo_full),
        .fetch_accept      (fetch_accept),
        .branch_valid      (branch_valid),
        .branch_address    (branch_address),
        .exception_valid   (exception_valid),
        .exception_address (exception_address),
        .xlate_flush       (xlate_flush),
        .tlb_req           (tlb_req),
        .tlb_vaddr         (tlb_vaddr),
        .tlb_ack           (tlb_ack),
        .tlb_paddr         (tlb_paddr),
        .tlb_miss          (tlb_miss),
        .tlb_illegal       (tlb_illegal),
        .tlb_invalid       (tlb_invalid),
        .tlb_uncached      (tlb_uncached),
        .pc_address        (pc_address),
        .pc_address_psy    (pc_address_psy),
        .pc_valid          (pc_valid),
        .pc_tlb_miss       (pc_tlb_miss),
        .pc_tlb_illegal    (pc_tlb_illegal),
        .pc_tlb_invalid    (pc_tlb_invalid),
        .pc_tlb_uncached   (pc_tlb_uncached)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] psy;
        logic        valid;
        logic        req;
        logic [3:0]  flags;  // {miss, illegal, invalid, uncached}
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst_n             = 1'b1;
        pc_en             = 1'b1;
        fifo_full         = 1'b0;
        fetch_accept      = 2'd0;
        branch_valid      = 1'b0;
        branch_address    = 32'h0;
        exception_valid   = 1'b0;
        exception_address = 32'h0;
        xlate_flush       = 1'b0;
        tlb_ack           = 1'b0;
        tlb_paddr         = 32'h0;
        tlb_miss          = 1'b0;
        tlb_illegal       = 1'b0;
        tlb_invalid       = 1'b0;
        tlb_uncached      = 1'b0;
    endtask

    // Inputs are already set; queue expectation, clock once, compare, return inputs to idle.
    task automatic tick(input logic [31:0] e_pc, input logic [31:0] e_psy,
                        input logic e_valid, input logic e_req, input logic [3:0] e_flags);
        exp_t e;
        e.pc = e_pc; e.psy = e_psy; e.valid = e_valid; e.req = e_req; e.flags = e_flags;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_val("pc", pc_address, e.pc);
        check_val("pc_valid", {31'b0, pc_valid}, {31'b0, e.valid});
        check_val("tlb_req", {31'b0, tlb_req}, {31'b0, e.req});
        if (e.valid) begin
            check_val("psy", pc_address_psy, e.psy);
            check_val("flags", {28'b0, pc_tlb_miss, pc_tlb_illegal, pc_tlb_invalid, pc_tlb_uncached},
                      {28'b0, e.flags});
        end
        if (e.req) check_val("tlb_vaddr", tlb_vaddr, e.pc);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #2;
        tick(32'hbfc00000, 32'h1fc00000, 1, 0, 4'b0001);
        // Advance, clamp and hold
        tick(32'hbfc00000, 32'h1fc00000, 1, 0, 4'b0001);
        fetch_accept = 2; tick(32'hbfc00008, 32'h1fc00008, 1, 0, 4'b0001);
        fetch_accept = 2; tick(32'hbfc00010, 32'h1fc00010, 1, 0, 4'b0001);
        fetch_accept = 3; tick(32'hbfc00018, 32'h1fc00018, 1, 0, 4'b0001);
        fifo_full = 1; fetch_accept = 2; tick(32'hbfc00018, 32'h1fc00018, 1, 0, 4'b0001);
        // Exception beats branch in the same cycle
        exception_valid = 1; exception_address = 32'h80000180;
        branch_valid = 1; branch_address = 32'h12345678;
        tick(32'h80000180, 32'h00000180, 1, 0, 4'b0000);
        fetch_accept = 2; tick(32'h80000188, 32'h00000188, 1, 0, 4'b0000);
        // Branch captured while stalled, applied ahead of advance
        for (int i = 0; i < 3; i++) begin
            pc_en = 0; fetch_accept = 2; branch_valid = 1; branch_address = 32'hbfc00100;
            tick(32'h80000188, 32'h00000188, 1, 0, 4'b0000);
        end
        fetch_accept = 2; tick(32'hbfc00100, 32'h1fc00100, 1, 0, 4'b0001);
        // Pending exception not overwritten by a later branch
        pc_en = 0; exception_valid = 1; exception_address = 32'h80000200;
        tick(32'hbfc00100, 32'h1fc00100, 1, 0, 4'b0001);
        pc_en = 0; branch_valid = 1; branch_address = 32'hbfc00300;
        tick(32'hbfc00100, 32'h1fc00100, 1, 0, 4'b0001);
        tick(32'h80000200, 32'h00000200, 1, 0, 4'b0000);
        // Mapped miss, ack after three request cycles, then cache hits
        branch_valid = 1; branch_address = 32'h00400000;
        tick(32'h00400000, 32'h0, 0, 1, 4'b0000);
        fetch_accept = 2; tick(32'h00400000, 32'h0, 0, 1, 4'b0000);
        tick(32'h00400000, 32'h0, 0, 1, 4'b0000);
        tlb_ack = 1; tlb_paddr = 32'h01234000;
        tick(32'h00400000, 32'h01234000, 1, 0, 4'b0000);
        fetch_accept = 2; tick(32'h00400008, 32'h01234008, 1, 0, 4'b0000);
        branch_valid = 1; branch_address = 32'h00400ff8;
        tick(32'h00400ff8, 32'h01234ff8, 1, 0, 4'b0000);
        fetch_accept = 2; tick(32'h00401000, 32'h0, 0, 1, 4'b0000);
        // Faulting result is reported but not cached
        tlb_ack = 1; tlb_paddr = 32'h05678000; tlb_miss = 1;
        tick(32'h00401000, 32'h05678000, 1, 0, 4'b1000);
        branch_valid = 1; branch_address = 32'h00401010;
        tick(32'h00401010, 32'h0, 0, 1, 4'b0000);
        // Redirect during lookup: result dropped, redirect applied after ack
        branch_valid = 1; branch_address = 32'hbfc00400;
        tick(32'h00401010, 32'h0, 0, 1, 4'b0000);
        tlb_ack = 1; tlb_paddr = 32'h05678010;
        tick(32'h00401010, 32'h0, 0, 0, 4'b0000);
        tick(32'hbfc00400, 32'h1fc00400, 1, 0, 4'b0001);
        // Flush invalidates the cached page
        branch_valid = 1; branch_address = 32'h00400010;
        tick(32'h00400010, 32'h01234010, 1, 0, 4'b0000);
        xlate_flush = 1; tick(32'h00400010, 32'h01234010, 1, 0, 4'b0000);
        branch_valid = 1; branch_address = 32'h00400020;
        tick(32'h00400020, 32'h0, 0, 1, 4'b0000);
        // Flush coinciding with fill: nothing cached
        tlb_ack = 1; tlb_paddr = 32'h01234020; xlate_flush = 1;
        tick(32'h00400020, 32'h01234020, 1, 0, 4'b0000);
        fetch_accept = 2; tick(32'h00400028, 32'h0, 0, 1, 4'b0000);
        tlb_ack = 1; tlb_paddr = 32'h01234028; tlb_uncached = 1;
        tick(32'h00400028, 32'h01234028, 1, 0, 4'b0001);
        fetch_accept = 1; tick(32'h0040002c, 32'h0123402c, 1, 0, 4'b0001);
        // Wrap past the top of the address space
        branch_valid = 1; branch_address = 32'hfffffffc;
        tick(32'hfffffffc, 32'h0, 0, 1, 4'b0000);
        tlb_ack = 1; tlb_paddr = 32'h00fffffc;
        tick(32'hfffffffc, 32'h00fffffc, 1, 0, 4'b0000);
        fetch_accept = 2; tick(32'h00000004, 32'h0, 0, 1, 4'b0000);
        // Reset in the middle of a lookup
        rst_n = 0; tick(32'hbfc00000, 32'h1fc00000, 1, 0, 4'b0001);
        tick(32'hbfc00000, 32'h1fc00000, 1, 0, 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_gen.md
Name: pc_fetch_gen

Overview:
Parametrised next-generation fetch PC generator.
- Advances by 0..FETCH_WIDTH instructions per cycle and applies exception/branch redirects.
- Redirects that arrive while stalled are held and applied later.
- Produces a physical address with TLB flags through a single handshaked TLB port, backed by a one-entry page translation cache, instead of one TLB port per candidate PC.
- Sits between the redirect logic in EX/CP0 and the I-cache/instruction FIFO.

Parameters:
FETCH_WIDTH, 2, max instructions consumed per cycle; power of two, 1..8
RESET_VECTOR, 32'hbfc0_0000, PC loaded on reset
PAGE_BITS, 12, page offset width for the translation cache compare

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock; reset is synchronous and active-low
pc_en  in  1  pipeline allows PC update
fifo_full  in  1  instruction FIFO full; hold PC
fetch_accept  in  $clog2(FETCH_WIDTH+1)  instructions consumed this cycle
branch_valid  in  1  branch redirect request
branch_address  in  32  branch target
exception_valid  in  1  exception redirect request
exception_address  in  32  exception vector
xlate_flush  in  1  invalidate cached translation (TLBW*/ASID change)
tlb_req  out  1  lookup request
tlb_vaddr  out  32  lookup virtual address
tlb_ack  in  1  lookup done; result inputs valid this cycle
tlb_paddr  in  32  translated address
tlb_miss, tlb_illegal, tlb_invalid, tlb_uncached  in  1 each  lookup flags
pc_address  out  32  current virtual PC
pc_address_psy  out  32  physical PC
pc_valid  out  1  pc_address_psy and flags valid
pc_tlb_miss, pc_tlb_illegal, pc_tlb_invalid, pc_tlb_uncached  out  1 each  registered flags

Behaviour:
- Reset (rst_n=0 at a clk edge), overriding everything including XLATE:
  - pc_address=RESET_VECTOR; pc_address_psy={3'b0,RESET_VECTOR[28:0]}; pc_tlb_uncached=RESET_VECTOR[29]; other flags 0.
  - pc_valid=1; tlb_req=0; state RUN; cache invalid; pending redirect cleared.
- Next-PC priority in RUN with pc_en=1:
  - live exception > pending redirect > live branch > fifo_full hold > advance > hold.
  - advance = pc + 4*min(fetch_accept,FETCH_WIDTH), modulo 2^32. fetch_accept=0 holds.
- Pending register:
  - Captures a redirect seen while pc_en=0 or state XLATE.
  - A pending exception is overwritten only by a newer exception. A pending branch is overwritten by an exception or a newer branch.
  - Cleared when applied.
- Translation of the new PC, computed combinationally and registered with the PC:
  - Unmapped (vaddr[31:30]==2'b10): psy={3'b0,vaddr[28:0]}; uncached=vaddr[29]; miss/illegal/invalid=0; pc_valid=1.
  - Mapped, cache hit (cache valid, VPN equal on bits [31:PAGE_BITS]): psy={cached PFN, vaddr[PAGE_BITS-1:0]} with cached uncached flag; pc_valid=1.
  - Mapped, cache miss: PC registers, pc_valid=0, next state XLATE.
- FSM RUN/XLATE:
  - XLATE asserts tlb_req with tlb_vaddr=pc_address.
  - tlb_req and tlb_vaddr are held stable until tlb_ack; ack may arrive in the same cycle as req.
  - On ack: result registered into psy/flags; pc_valid=1 the next cycle; return to RUN.
  - Cache fill only when miss/illegal/invalid all 0; faulting results leave the cache invalid.
- Redirect during XLATE: latched pending; lookup completes; result discarded; pending redirect applied in the RUN cycle after ack; pc_valid stays 0 meanwhile.
- PC advance is blocked in XLATE.
- xlate_flush: cache invalid from the next cycle. If flush and fill coincide, flush wins.
- pc_en=0: PC, psy, flags, pc_valid held; redirects are captured into pending.

Decomposition:
- Package sirius_fetch_pkg:
  - pc_xlate_t struct {paddr[31:0], miss, illegal, invalid, uncached}.
  - fetch_state_e {RUN, XLATE}.
  - redirect_e {NONE, BRANCH, EXCEPTION}.
  - KSEG_UNMAPPED constant 2'b10.
- Sub-module pc_xlate_cache: single-entry VPN/PFN/uncached store with hit compare, fill and flush.

Test Plan:
- Reset, then fetch_accept=2 for 2 cycles -> pc 0xbfc00000, 0xbfc00008, 0xbfc00010; psy 0x1fc00010; uncached=1; no tlb_req.
- exception_valid (0x80000180) and branch_valid same cycle -> pc=0x80000180, psy=0x00000180, uncached=0; branch dropped.
- pc_en=0 with branch to 0xbfc00100 for 3 cycles, then pc_en=1 and fetch_accept=2 -> pc=0xbfc00100, not +8.
- Branch to mapped 0x00400000 -> pc_valid=0, tlb_req=1 next cycle. Ack 3 cycles later with paddr 0x01234000 -> psy=0x01234000. Advance to 0x00400008 -> hit, no tlb_req. Advance to 0x00401000 -> new lookup.
- tlb_ack with tlb_miss=1 -> pc_tlb_miss=1, pc_valid=1; a re-branch to the same page issues a new tlb_req (no caching).
- pc=0xfffffffc (mapped) with fetch_accept=2 -> pc=0x00000004, lookup issued. rst_n=0 mid-XLATE -> tlb_req=0, pc=0xbfc00000 next cycle.
